// File: rtl/ikbd_input_frontend_if.sv
// ikbd_input_frontend_if: host-event and 6301 pin bundle for the ikbd input front end
//   master: event source / pin driver (key events, column drive, mouse reports)
//   slave : front end (returns row sense, quadrature, buttons)
interface ikbd_input_frontend_if #(
  parameter int COLS  = 15,
  parameter int ROWS  = 8,
  parameter int KEY_W = 7
);
  logic             key_strobe;
  logic [KEY_W-1:0] key_code;
  logic             key_make;
  logic             key_clear;
  logic [COLS-1:0]  col_drive;
  logic [ROWS-1:0]  row_sense;
  logic             mouse_strobe;
  logic [7:0]       mouse_dx;
  logic [7:0]       mouse_dy;
  logic [1:0]       mouse_btn;
  logic [3:0]       quad;
  logic [1:0]       btn_n;
  modport master (
    output key_strobe, key_code, key_make, key_clear, col_drive,
           mouse_strobe, mouse_dx, mouse_dy, mouse_btn,
    input  row_sense, quad, btn_n
  );
  modport slave (
    input  key_strobe, key_code, key_make, key_clear, col_drive,
           mouse_strobe, mouse_dx, mouse_dy, mouse_btn,
    output row_sense, quad, btn_n
  );
endinterface

// File: rtl/ikbd_input_frontend.sv
// ikbd_input_frontend: host-driven key matrix and paced mouse quadrature for the ikbd 6301
//   clk, res_n : clock, asynchronous active-low reset
//   bus        : key events, column drive/row sense, mouse reports, quad {YB,YA,XB,XA}, btn_n
module ikbd_input_frontend #(
  parameter int COLS  = 15,
  parameter int ROWS  = 8,
  parameter int KEY_W = 7,
  parameter int QDIV  = 1000,
  parameter int ACC_W = 10
) (
  input logic                  clk,
  input logic                  res_n,
  ikbd_input_frontend_if.slave bus
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = KEY_W - RW;
  localparam int QW = $clog2(QDIV);
  // wide enough for acc + full 8-bit delta +/- step without overflow
  localparam int SW = (ACC_W > 8 ? ACC_W : 8) + 2;
  localparam logic signed [SW-1:0] MAX = SW'((2 ** (ACC_W - 1)) - 1);
  logic [COLS-1:0][ROWS-1:0] key_q, key_d;
  logic [1:0]                btn_q;
  logic [RW-1:0]             row;
  logic [CW-1:0]             col;
  logic [ROWS-1:0]           hit;
  logic [1:0]                ab [2];
  assign row = bus.key_code[RW-1:0];
  assign col = bus.key_code[KEY_W-1:RW];
  always_comb begin
    key_d = key_q;
    if (bus.key_clear) key_d = '0;
    else if (bus.key_strobe && int'(col) < COLS) key_d[col][row] = bus.key_make;
  end
  // rows of every low-driven column merge; no ghosting model
  always_comb begin
    hit = '0;
    for (int c = 0; c < COLS; c++) hit |= key_q[c] & {ROWS{~bus.col_drive[c]}};
  end
  assign bus.row_sense = ~hit;
  always_ff @(posedge clk or negedge res_n)
    if (!res_n) begin
      key_q <= '0;
      btn_q <= 2'b11;
    end else begin
      key_q <= key_d;
      btn_q <= bus.mouse_strobe ? ~bus.mouse_btn : btn_q;
    end
  assign bus.btn_n = btn_q;
  for (genvar a = 0; a < 2; a++) begin : g_axis
    logic [QW-1:0]           cnt_q;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [1:0]              ph_q, ph_d, ab_q;
    logic signed [7:0]       dlt;
    logic signed [SW-1:0]    sum;
    logic                    wrap, up, dn;
    assign dlt  = a == 1 ? bus.mouse_dy : bus.mouse_dx;
    assign wrap = cnt_q == QW'(QDIV - 1);
    always_comb begin
      up    = wrap && acc_q > 0;
      dn    = wrap && acc_q < 0;
      sum   = SW'(acc_q) + (bus.mouse_strobe ? SW'(dlt) : '0) - SW'(up) + SW'(dn);
      acc_d = sum > MAX ? ACC_W'(MAX) : sum < -MAX ? ACC_W'(-MAX) : ACC_W'(sum);
      ph_d  = ph_q + (dn ? 2'd3 : {1'b0, up});
    end
    // ab_q = {B, A}: A = p[1], B = p[1]^p[0]
    always_ff @(posedge clk or negedge res_n)
      if (!res_n) begin
        cnt_q <= '0;
        acc_q <= '0;
        ph_q  <= '0;
        ab_q  <= '0;
      end else begin
        cnt_q <= wrap ? '0 : cnt_q + 1'b1;
        acc_q <= acc_d;
        ph_q  <= ph_d;
        ab_q  <= {ph_d[1] ^ ph_d[0], ph_d[1]};
      end
    assign ab[a] = ab_q;
  end
  assign bus.quad = {ab[1], ab[0]};
endmodule

// File: tb/tb_ikbd_input_frontend.sv
// tb_ikbd_input_frontend: directed self-checking bench for ikbd_input_frontend
module tb_ikbd_input_frontend;
  logic clk = 1'b0;
  logic res_n = 1'b0;
  always #5 clk = ~clk;
  ikbd_input_frontend_if #(.COLS(15), .ROWS(8), .KEY_W(7)) bus();
  ikbd_input_frontend #(.COLS(15), .ROWS(8), .KEY_W(7), .QDIV(4), .ACC_W(6)) dut (
    .clk(clk), .res_n(res_n), .bus(bus.slave)
  );
  int checks = 0, errors = 0, cyc = 0;
  int xpos = 0, ypos = 0, ychg = 0, bad = 0;
  int x0, y0, t1, t2, t3;
  logic [1:0] xp = 2'b00, yp = 2'b00;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [1:0] dif(input logic [1:0] o, input logic [1:0] n);
    logic [1:0] po, pn;
    po = {o[0], o[0] ^ o[1]};
    pn = {n[0], n[0] ^ n[1]};
    return pn - po;
  endfunction
  function automatic int mv(input logic [1:0] o, input logic [1:0] n);
    return dif(o, n) == 2'd1 ? 1 : dif(o, n) == 2'd3 ? -1 : 0;
  endfunction
  always @(negedge clk)
    if (!res_n) begin
      xp <= 2'b00;
      yp <= 2'b00;
    end else begin
      xpos <= xpos + mv(xp, bus.quad[1:0]);
      ypos <= ypos + mv(yp, bus.quad[3:2]);
      ychg <= ychg + int'(yp != bus.quad[3:2]);
      bad  <= bad + int'(dif(xp, bus.quad[1:0]) == 2'd2) + int'(dif(yp, bus.quad[3:2]) == 2'd2);
      xp   <= bus.quad[1:0];
      yp   <= bus.quad[3:2];
    end
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic key(input logic [6:0] code, input logic make);
    bus.key_code   = code;
    bus.key_make   = make;
    bus.key_strobe = 1'b1;
    tick;
    bus.key_strobe = 1'b0;
  endtask
  task automatic mouse(input logic [7:0] dx, input logic [7:0] dy, input logic [1:0] btn);
    bus.mouse_dx     = dx;
    bus.mouse_dy     = dy;
    bus.mouse_btn    = btn;
    bus.mouse_strobe = 1'b1;
    tick;
    bus.mouse_strobe = 1'b0;
  endtask
  task automatic wait_x(output int at);
    logic [1:0] p;
    int n;
    p = bus.quad[1:0];
    n = 0;
    while (bus.quad[1:0] == p && n < 20) begin
      tick;
      n++;
    end
    check("x_step_seen", 32'(n < 20), 1);
    at = cyc;
  endtask
  initial begin
    bus.key_strobe = 0; bus.key_code = 0; bus.key_make = 0; bus.key_clear = 0;
    bus.col_drive = '1; bus.mouse_strobe = 0; bus.mouse_dx = 0; bus.mouse_dy = 0;
    bus.mouse_btn = 0;
    repeat (3) tick;
    check("rst_row", bus.row_sense, 8'hFF);
    check("rst_quad", bus.quad, 4'h0);
    check("rst_btn", bus.btn_n, 2'b11);
    res_n = 1'b1;
    tick;
    mouse(8'd0, 8'd0, 2'b01);
    check("btn_set", bus.btn_n, 2'b10);
    bus.mouse_btn = 2'b10;
    tick;
    check("btn_hold", bus.btn_n, 2'b10);
    mouse(8'd0, 8'd0, 2'b10);
    check("btn_upd", bus.btn_n, 2'b01);
    bus.col_drive = ~15'h0002;
    bus.key_code = 7'h0B; bus.key_make = 1'b1; bus.key_strobe = 1'b1;
    check("key_before_edge", bus.row_sense, 8'hFF);
    tick;
    bus.key_strobe = 1'b0;
    check("key_press", bus.row_sense, 8'hF7);
    bus.col_drive = ~15'h0001;
    #1 check("key_other_col", bus.row_sense, 8'hFF);
    bus.col_drive = ~15'h0002;
    key(7'h0B, 1'b0);
    check("key_release", bus.row_sense, 8'hFF);
    key(7'h0B, 1'b1);
    key(7'h13, 1'b1);
    bus.col_drive = ~15'h0006;
    #1 check("key_merge", bus.row_sense, 8'hF7);
    bus.col_drive = ~15'h0004;
    #1 check("key_col2", bus.row_sense, 8'hF7);
    bus.col_drive = '0;
    key(7'h7F, 1'b1);
    check("key_col_oob", bus.row_sense, 8'hF7);
    key(7'h77, 1'b1);
    check("key_col14", bus.row_sense, 8'h77);
    bus.col_drive = '1;
    #1 check("key_no_drive", bus.row_sense, 8'hFF);
    bus.col_drive = '0;
    bus.key_clear = 1'b1;
    key(7'h01, 1'b1);
    bus.key_clear = 1'b0;
    check("key_clear", bus.row_sense, 8'hFF);
    bus.col_drive = '1;
    mouse(8'd3, 8'd0, 2'b10);
    wait_x(t1);
    check("x3_s1", bus.quad[1:0], 2'b10);
    wait_x(t2);
    check("x3_s2", bus.quad[1:0], 2'b11);
    check("x3_gap1", t2 - t1, 4);
    wait_x(t3);
    check("x3_s3", bus.quad[1:0], 2'b01);
    check("x3_gap2", t3 - t2, 4);
    repeat (12) tick;
    check("x3_static", bus.quad[1:0], 2'b01);
    mouse(8'hFE, 8'd0, 2'b10);
    wait_x(t1);
    check("xm2_s1", bus.quad[1:0], 2'b11);
    wait_x(t2);
    check("xm2_s2", bus.quad[1:0], 2'b10);
    check("xm2_gap", t2 - t1, 4);
    repeat (12) tick;
    check("xm2_static", bus.quad[1:0], 2'b10);
    mouse(8'd2, 8'd0, 2'b10);
    wait_x(t1);
    check("coin_pre", bus.quad[1:0], 2'b11);
    repeat (3) tick;
    x0 = xpos;
    mouse(8'd5, 8'd0, 2'b10);
    check("coin_step", bus.quad[1:0], 2'b01);
    repeat (40) tick;
    check("coin_total", xpos - x0, 6);
    check("coin_phase", bus.quad[1:0], 2'b00);
    bus.mouse_dx = 8'd127; bus.mouse_dy = 8'd0; bus.mouse_strobe = 1'b1;
    repeat (5) tick;
    bus.mouse_strobe = 1'b0;
    @(negedge clk);
    #1 x0 = xpos;
    repeat (136) tick;
    check("sat_pos_steps", xpos - x0, 31);
    check("sat_pos_phase", bus.quad[1:0], 2'b00);
    x0 = xpos;
    mouse(8'h80, 8'd0, 2'b10);
    repeat (136) tick;
    check("sat_neg_steps", xpos - x0, -31);
    check("sat_neg_phase", bus.quad[1:0], 2'b10);
    check("y_static", ychg, 0);
    y0 = ypos;
    mouse(8'd0, 8'hFF, 2'b10);
    repeat (10) tick;
    check("y_back", bus.quad[3:2], 2'b01);
    check("y_pos", ypos - y0, -1);
    bus.col_drive = ~15'h0002;
    key(7'h0B, 1'b1);
    check("rst_key_held", bus.row_sense, 8'hF7);
    mouse(8'd20, 8'd0, 2'b11);
    check("rst_btn_pre", bus.btn_n, 2'b00);
    repeat (10) tick;
    #3 res_n = 1'b0;
    #1;
    check("async_row", bus.row_sense, 8'hFF);
    check("async_quad", bus.quad, 4'h0);
    check("async_btn", bus.btn_n, 2'b11);
    repeat (2) tick;
    res_n = 1'b1;
    tick;
    check("post_rst_row", bus.row_sense, 8'hFF);
    x0 = xpos;
    repeat (30) tick;
    check("post_rst_quad", bus.quad, 4'h0);
    check("post_rst_steps", xpos - x0, 0);
    check("quad_gray", bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
